// File: rtl/alu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for an 8-bit ALU datapath.
// Fetches 9-bit instructions, drives register-file and ALU controls, and latches flags for branches.
module alu_seq_ctrl #(
  parameter int PCW = 8,
  parameter int IW  = 9
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  output logic           InstReq,
  output logic [PCW-1:0] InstAddr,
  input  logic           InstValid,
  input  logic [IW-1:0]  InstData,
  output logic [2:0]     AluOp,
  output logic [2:0]     RegRdAddrA,
  output logic [2:0]     RegRdAddrB,
  output logic           RegWrEn,
  output logic [2:0]     RegWrAddr,
  output logic           WrSelImm,
  output logic [7:0]     Imm,
  input  logic           AluZero,
  input  logic           AluParity,
  input  logic           AluOdd,
  output logic           FlagZ,
  output logic           FlagP,
  output logic           FlagO,
  output logic           Busy,
  output logic           Done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  localparam logic [1:0] CTRL_LDI  = 2'b00;
  localparam logic [1:0] CTRL_BRZ  = 2'b01;
  localparam logic [1:0] CTRL_BRO  = 2'b10;

  state_t         state, next_state;
  logic [PCW-1:0] pc;
  logic [IW-1:0]  ir;
  logic           flag_z, flag_p, flag_o;

  logic           is_ctrl;
  logic [1:0]     ctrl;
  logic [2:0]     rd;
  logic [1:0]     rb;
  logic [5:0]     imm6;
  logic [PCW-1:0] br_off;
  logic           taken;

  assign is_ctrl = ir[8];
  assign ctrl    = ir[7:6];
  assign rd      = ir[4:2];
  assign rb      = ir[1:0];
  assign imm6    = ir[5:0];
  assign br_off  = {{(PCW-6){imm6[5]}}, imm6};
  assign taken   = ((ctrl == CTRL_BRZ) && flag_z) || ((ctrl == CTRL_BRO) && flag_o);

  // NOTE: sequential state uses non-blocking assignments under an async active-low reset,
  // so every register sees pre-edge values and clears the instant Reset falls.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc     <= '0;
      ir     <= '0;
      flag_z <= 1'b0;
      flag_p <= 1'b0;
      flag_o <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_HALTED: if (Start) pc <= '0;
        S_FETCH:          if (InstValid) ir <= InstData;
        S_EXEC: begin
          flag_z <= AluZero;
          flag_p <= AluParity;
          flag_o <= AluOdd;
          pc     <= pc + PCW'(1);
        end
        S_WB:     pc <= pc + PCW'(1);
        S_BRANCH: pc <= taken ? pc + br_off : pc + PCW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default before the case, so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   if (Start) next_state = S_FETCH;
      S_FETCH:  if (InstValid) next_state = S_DECODE;
      S_DECODE: begin
        if (!is_ctrl) next_state = S_EXEC;
        else begin
          unique case (ctrl)
            CTRL_LDI:           next_state = S_WB;
            CTRL_BRZ, CTRL_BRO: next_state = S_BRANCH;
            default:            next_state = S_HALTED;
          endcase
        end
      end
      S_EXEC, S_WB, S_BRANCH: next_state = S_FETCH;
      S_HALTED: if (Start) next_state = S_FETCH;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    InstReq    = 1'b0;
    AluOp      = 3'd0;
    RegRdAddrA = 3'd0;
    RegRdAddrB = 3'd0;
    RegWrEn    = 1'b0;
    RegWrAddr  = 3'd0;
    WrSelImm   = 1'b0;
    Imm        = 8'd0;
    Busy       = 1'b0;
    Done       = 1'b0;
    unique case (state)
      S_FETCH: begin
        InstReq = 1'b1;
        Busy    = 1'b1;
      end
      S_DECODE: begin
        AluOp      = ir[7:5];
        RegRdAddrA = rd;
        RegRdAddrB = {1'b0, rb};
        Busy       = 1'b1;
      end
      S_EXEC: begin
        AluOp      = ir[7:5];
        RegRdAddrA = rd;
        RegRdAddrB = {1'b0, rb};
        RegWrEn    = 1'b1;
        RegWrAddr  = rd;
        Busy       = 1'b1;
      end
      S_WB: begin
        RegWrEn  = 1'b1;
        WrSelImm = 1'b1;
        Imm      = {2'b00, imm6};
        Busy     = 1'b1;
      end
      S_BRANCH: Busy = 1'b1;
      S_HALTED: Done = 1'b1;
      default: ;
    endcase
  end

  assign InstAddr = pc;
  assign FlagZ    = flag_z;
  assign FlagP    = flag_p;
  assign FlagO    = flag_o;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: bench-side instruction memory, register file and ALU model,
// with scoreboards of expected fetch addresses and register writes.
module tb_alu_seq_ctrl;
  localparam int PCW = 8;
  localparam int IW  = 9;

  logic           Clk = 1'b0;
  logic           Reset;
  logic           Start;
  logic           InstReq;
  logic [PCW-1:0] InstAddr;
  logic           InstValid;
  logic [IW-1:0]  InstData;
  logic [2:0]     AluOp, RegRdAddrA, RegRdAddrB, RegWrAddr;
  logic           RegWrEn, WrSelImm;
  logic [7:0]     Imm;
  logic           AluZero, AluParity, AluOdd;
  logic           FlagZ, FlagP, FlagO, Busy, Done;

  alu_seq_ctrl #(.PCW(PCW), .IW(IW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .InstReq(InstReq), .InstAddr(InstAddr), .InstValid(InstValid), .InstData(InstData),
    .AluOp(AluOp), .RegRdAddrA(RegRdAddrA), .RegRdAddrB(RegRdAddrB),
    .RegWrEn(RegWrEn), .RegWrAddr(RegWrAddr), .WrSelImm(WrSelImm), .Imm(Imm),
    .AluZero(AluZero), .AluParity(AluParity), .AluOdd(AluOdd),
    .FlagZ(FlagZ), .FlagP(FlagP), .FlagO(FlagO), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;
  int mem_wait = 0;
  int wait_ctr = 0;
  bit force_ra0 = 1'b0;

  logic [8:0]  imem [256];
  logic [7:0]  regs [8];
  logic [10:0] sb_wr [$];
  logic [7:0]  sb_fetch [$];
  logic [7:0]  alu_y;
  logic [2:0]  ra_eff;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return (a < b) ? 8'd1 : 8'd0;
      default: return (a == b) ? 8'd1 : 8'd0;
    endcase
  endfunction

  function automatic logic [8:0] i_alu(input logic [2:0] op, input logic [2:0] rd, input logic [1:0] rb);
    return {1'b0, op, rd, rb};
  endfunction
  function automatic logic [8:0] i_ldi(input logic [5:0] v); return {3'b100, v}; endfunction
  function automatic logic [8:0] i_brz(input logic [5:0] v); return {3'b101, v}; endfunction
  function automatic logic [8:0] i_bro(input logic [5:0] v); return {3'b110, v}; endfunction
  function automatic logic [8:0] i_halt(); return 9'b111_000000; endfunction

  // Bench ALU: combinational from the register model, optionally reading r0 as operand A.
  always_comb begin
    ra_eff    = force_ra0 ? 3'd0 : RegRdAddrA;
    alu_y     = alu_f(AluOp, regs[ra_eff], regs[RegRdAddrB]);
    AluZero   = (alu_y == 8'd0);
    AluParity = ^alu_y;
    AluOdd    = alu_y[0];
  end

  // Instruction memory with a programmable number of wait cycles per fetch.
  initial begin
    InstValid = 1'b0;
    InstData  = '0;
    forever begin
      @(negedge Clk);
      if (InstReq) begin
        if (wait_ctr >= mem_wait) begin
          InstValid = 1'b1;
          InstData  = imem[InstAddr];
          wait_ctr  = 0;
          n_cmp++;
          assert (sb_fetch.size() != 0) else begin
            n_err++;
            $error("FAIL fetch_unexpected: observed addr 0x%0h expected no fetch", InstAddr);
          end
          if (sb_fetch.size() != 0) check("fetch_addr", 32'(InstAddr), 32'(sb_fetch.pop_front()));
        end else begin
          InstValid = 1'b0;
          wait_ctr++;
        end
      end else begin
        InstValid = 1'b0;
        wait_ctr  = 0;
      end
    end
  end

  // Register-write scoreboard; the model register file updates on the following edge.
  initial begin
    logic [7:0] wd;
    logic [2:0] wa;
    forever begin
      @(negedge Clk);
      if (RegWrEn) begin
        wd = WrSelImm ? Imm : alu_y;
        wa = RegWrAddr;
        n_cmp++;
        assert (sb_wr.size() != 0) else begin
          n_err++;
          $error("FAIL reg_write_unexpected: observed r%0d=0x%0h expected no write", wa, wd);
        end
        if (sb_wr.size() != 0) check("reg_write", 32'({wa, wd}), 32'(sb_wr.pop_front()));
        @(posedge Clk);
        if (Reset) regs[wa] = wd;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) imem[i] = i_halt();
    for (int i = 0; i < 8; i++) regs[i] = 8'd0;
  endtask

  task automatic pulse_start();
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
  endtask

  task automatic run_until_done(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (Done) break;
      @(negedge Clk);
    end
    check(tag, 32'(Done), 32'd1);
    check("wr_queue_empty", 32'(sb_wr.size()), 32'd0);
    check("fetch_queue_empty", 32'(sb_fetch.size()), 32'd0);
  endtask

  initial begin
    bit seen;
    Reset = 1'b0;
    Start = 1'b0;
    mem_wait = 50;
    clear_prog();

    // Reset state, then reset asserted in the middle of a stalled fetch.
    repeat (3) @(negedge Clk);
    #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_instreq", 32'(InstReq), 32'd0);
    check("rst_flags", 32'({FlagZ, FlagP, FlagO}), 32'd0);
    @(negedge Clk); Reset = 1'b1;
    pulse_start();
    @(negedge Clk); @(negedge Clk);
    check("fetch_wait_req", 32'(InstReq), 32'd1);
    #2 Reset = 1'b0;
    #1;
    check("async_rst_instreq", 32'(InstReq), 32'd0);
    check("async_rst_busy", 32'(Busy), 32'd0);
    check("async_rst_addr", 32'(InstAddr), 32'd0);
    @(negedge Clk); Reset = 1'b1; mem_wait = 0;

    // LDI 5; ADD r1 <- r0 + r0; HALT with zero-wait memory.
    clear_prog();
    imem[0] = i_ldi(6'h05);
    imem[1] = i_alu(3'd0, 3'd1, 2'd0);
    imem[2] = i_halt();
    force_ra0 = 1'b1;
    sb_wr.push_back({3'd0, 8'h05});
    sb_wr.push_back({3'd1, 8'h0A});
    sb_fetch.push_back(8'd0); sb_fetch.push_back(8'd1); sb_fetch.push_back(8'd2);
    pulse_start();
    #1;
    check("first_fetch_req", 32'(InstReq), 32'd1);
    check("first_fetch_addr", 32'(InstAddr), 32'd0);
    repeat (7) @(negedge Clk);
    check("done_c8", 32'(Done), 32'd0);
    @(negedge Clk);
    check("done_c9", 32'(Done), 32'd1);
    check("busy_halted", 32'(Busy), 32'd0);
    check("flags_add", 32'({FlagZ, FlagP, FlagO}), 32'd0);
    run_until_done("done_prog_a");
    force_ra0 = 1'b0;

    // AND to zero at PC=5 then BRZ -3 (taken), second pass not taken to PC=7.
    clear_prog();
    imem[0] = i_ldi(6'h0C);
    imem[1] = i_alu(3'd0, 3'd1, 2'd0);
    imem[2] = i_ldi(6'h03);
    imem[3] = i_alu(3'd4, 3'd1, 2'd0);
    imem[4] = i_ldi(6'h30);
    imem[5] = i_alu(3'd2, 3'd1, 2'd0);
    imem[6] = i_brz(6'b111101);
    imem[7] = i_halt();
    sb_wr.push_back({3'd0, 8'h0C}); sb_wr.push_back({3'd1, 8'h0C});
    sb_wr.push_back({3'd0, 8'h03}); sb_wr.push_back({3'd1, 8'h0F});
    sb_wr.push_back({3'd0, 8'h30}); sb_wr.push_back({3'd1, 8'h00});
    sb_wr.push_back({3'd1, 8'h30}); sb_wr.push_back({3'd0, 8'h30});
    sb_wr.push_back({3'd1, 8'h30});
    foreach (imem[i]) if (i <= 6) sb_fetch.push_back(8'(i));
    sb_fetch.push_back(8'd3); sb_fetch.push_back(8'd4); sb_fetch.push_back(8'd5);
    sb_fetch.push_back(8'd6); sb_fetch.push_back(8'd7);
    pulse_start();
    run_until_done("done_brz");
    check("flags_brz", 32'({FlagZ, FlagP, FlagO}), 32'd0);

    // Set FlagO/FlagP with OR r0|r0 = 1.
    clear_prog();
    imem[0] = i_ldi(6'h01);
    imem[1] = i_alu(3'd3, 3'd0, 2'd0);
    sb_wr.push_back({3'd0, 8'h01}); sb_wr.push_back({3'd0, 8'h01});
    sb_fetch.push_back(8'd0); sb_fetch.push_back(8'd1); sb_fetch.push_back(8'd2);
    pulse_start();
    run_until_done("done_or");
    check("flags_or", 32'({FlagZ, FlagP, FlagO}), 32'b011);

    // Restart from HALTED: BRO -1 wraps 0 -> 255, ALU at 255 wraps to 0, BRO falls through.
    imem[0]   = i_bro(6'b111111);
    imem[1]   = i_halt();
    imem[255] = i_alu(3'd2, 3'd2, 2'd0);
    sb_wr.push_back({3'd2, 8'h00});
    sb_fetch.push_back(8'd0); sb_fetch.push_back(8'd255);
    sb_fetch.push_back(8'd0); sb_fetch.push_back(8'd1);
    pulse_start();
    #1;
    check("restart_done_low", 32'(Done), 32'd0);
    check("restart_addr", 32'(InstAddr), 32'd0);
    check("restart_flags_kept", 32'({FlagZ, FlagP, FlagO}), 32'b011);
    run_until_done("done_bro");
    check("flags_bro", 32'({FlagZ, FlagP, FlagO}), 32'b100);

    // Four wait cycles per fetch; Start pulses during the second fetch are ignored.
    clear_prog();
    mem_wait = 4;
    imem[0] = i_ldi(6'h21);
    imem[1] = i_ldi(6'h15);
    sb_wr.push_back({3'd0, 8'h21}); sb_wr.push_back({3'd0, 8'h15});
    sb_fetch.push_back(8'd0); sb_fetch.push_back(8'd1); sb_fetch.push_back(8'd2);
    pulse_start();
    repeat (7) @(negedge Clk);
    for (int i = 0; i < 5; i++) begin
      Start = (i < 4);
      #1;
      check("wait_req", 32'(InstReq), 32'd1);
      check("wait_addr", 32'(InstAddr), 32'd1);
      check("wait_no_wr", 32'(RegWrEn), 32'd0);
      @(negedge Clk);
    end
    Start = 1'b0;
    run_until_done("done_wait");
    mem_wait = 0;

    // Reset asserted during EXEC drops RegWrEn and the flags immediately.
    clear_prog();
    imem[0] = i_ldi(6'h07);
    imem[1] = i_alu(3'd0, 3'd3, 2'd0);
    sb_wr.push_back({3'd0, 8'h07}); sb_wr.push_back({3'd3, 8'h07});
    sb_fetch.push_back(8'd0); sb_fetch.push_back(8'd1);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (RegWrEn && RegWrAddr == 3'd3) begin
        seen = 1'b1;
        break;
      end
    end
    check("exec_reached", 32'(seen), 32'd1);
    check("flagz_before_rst", 32'(FlagZ), 32'd1);
    #2 Reset = 1'b0;
    #1;
    check("async_rst_wren", 32'(RegWrEn), 32'd0);
    check("async_rst_wraddr", 32'(RegWrAddr), 32'd0);
    check("async_rst_aluop", 32'(AluOp), 32'd0);
    check("async_rst_flags", 32'({FlagZ, FlagP, FlagO}), 32'd0);
    check("async_rst_busy2", 32'(Busy), 32'd0);
    check("wr_queue_final", 32'(sb_wr.size()), 32'd0);
    check("fetch_queue_final", 32'(sb_fetch.size()), 32'd0);
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Multi-cycle control sequencer that drives the 8-bit combinational ALU. It fetches 9-bit instructions over a req/valid handshake and decodes them into ALU opcode, register-file read/write controls and immediates. It latches the ALU status flags (Zero/Parity/Odd) and resolves conditional branches from them. It sits between instruction memory, the register file and the ALU; the datapath itself lives outside this block.

Parameters:
PCW, 8, program counter / instruction address width
IW, 9, instruction width (fixed encoding below; only 9 is supported)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
Start  in  1  begin execution at PC=0 (sampled in IDLE/HALTED only)
InstReq  out  1  instruction fetch request
InstAddr  out  PCW  fetch address (=PC)
InstValid  in  1  instruction memory returns InstData this cycle
InstData  in  IW  instruction word
AluOp  out  3  ALU opcode (Inst[7:5])
RegRdAddrA  out  3  register file read port A (ALU InputA)
RegRdAddrB  out  3  register file read port B (ALU InputB)
RegWrEn  out  1  register file write strobe
RegWrAddr  out  3  write address
WrSelImm  out  1  1: write data = Imm; 0: write data = ALU Out
Imm  out  8  immediate value
AluZero, AluParity, AluOdd  in  1 each  ALU status flags
FlagZ, FlagP, FlagO  out  1 each  latched flags
Busy  out  1  high in FETCH/DECODE/EXEC/WB/BRANCH
Done  out  1  high in HALTED

Behaviour:
- Encoding. Inst[8]=0 is an ALU op: AluOp=Inst[7:5], rd=Inst[4:2], rA=rd, rB={1'b0,Inst[1:0]}.
- Inst[8]=1, Inst[7:6] selects: 00 LDI (r0 <= {2'b00,Inst[5:0]}); 01 BRZ (taken if FlagZ); 10 BRO (taken if FlagO); 11 HALT.
- Reset low, effective immediately: state=IDLE, PC=0, IR=0, flags=0. Every output is 0, including RegWrEn, which drops asynchronously even mid-EXEC.
- IDLE: Start=1 -> PC<=0, go to FETCH.
- FETCH: InstReq=1 and InstAddr=PC, both held stable until InstValid=1. On that edge IR<=InstData and go to DECODE. InstValid is ignored whenever InstReq=0.
- DECODE (1 cycle): RegRdAddrA/B and AluOp are driven from IR. Next state: ALU op -> EXEC; LDI -> WB; BRZ/BRO -> BRANCH; HALT -> HALTED.
- EXEC (1 cycle): AluOp, RegRdAddrA/B held; RegWrEn=1, RegWrAddr=rd, WrSelImm=0. At the end of the cycle FlagZ/P/O <= AluZero/AluParity/AluOdd, PC<=PC+1, go to FETCH.
- WB (LDI, 1 cycle): RegWrEn=1, RegWrAddr=0, WrSelImm=1, Imm={2'b00,IR[5:0]}. Flags unchanged. PC<=PC+1, go to FETCH.
- BRANCH (1 cycle): if taken, PC <= PC + sign-extend(IR[5:0]); otherwise PC <= PC+1. Go to FETCH. Flags unchanged.
- HALTED: Done=1, Busy=0, PC held. Start=1 -> PC<=0, Done<=0, go to FETCH.
- Start is ignored while Busy=1.
- AluOp, RegRdAddrA/B and RegWrAddr are 0 outside DECODE/EXEC/WB. Imm is 0 outside WB.
- RegWrEn is high exactly one cycle per ALU/LDI instruction and never in any other state.
- PC arithmetic is modulo 2^PCW; wrap in both directions is legal. A taken branch with offset 0 is a legal self-loop.
- Flags update only in EXEC, and compare ops (result 0/1) update them the same way.
- Minimum latency with InstValid returned in the same cycle as InstReq: 3 cycles per instruction (FETCH, DECODE, EXEC/WB/BRANCH). Each FETCH wait cycle adds 1.

Test Plan:
- Reset low mid-FETCH -> all outputs 0 asynchronously; after release and Start, InstAddr=0 and InstReq=1 on the next cycle.
- Program [LDI 0x05; ALU ADD rd=1,rB=0 with rA forced to r0 by bench model; HALT], zero-wait memory -> WB writes 0x05 to r0. EXEC writes 0x0A with RegWrAddr=1, FlagZ=0, FlagO=0, FlagP=0. Done=1 at cycle 9 after Start.
- ALU AND producing 0x00 at PC=5 (FlagZ=1), then BRZ offset -3 at PC=6 -> next InstAddr=3. Same with FlagZ=0 -> InstAddr=7.
- PCW=8, PC=0, FlagO=1, BRO offset -1 -> InstAddr=255. Then from PC=255, ALU op -> InstAddr=0.
- InstValid delayed 4 cycles -> InstReq/InstAddr stable for 5 cycles, no RegWrEn, Start pulses during the wait ignored.
- HALT reached, then Start -> Done falls next cycle and fetch restarts at InstAddr=0 with flags retained.
